// File: rtl/stage_threshold_evaluator_pkg.sv
// Shared types and constants for the cascade stage threshold evaluator.
package stage_threshold_evaluator_pkg;

   // Stage index / stage count width
   localparam int unsigned DATA_WIDTH_8  = 8;
   // Per-classifier haar value width (signed)
   localparam int unsigned DATA_WIDTH_12 = 12;
   // Stage accumulator and threshold width (signed)
   localparam int unsigned DATA_WIDTH_16 = 16;

   localparam logic signed [DATA_WIDTH_16-1:0] SAT_MAX_16 = 16'sh7FFF;
   localparam logic signed [DATA_WIDTH_16-1:0] SAT_MIN_16 = 16'sh8000;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StAccum   = 2'd1,
      StCompare = 2'd2,
      StResult  = 2'd3
   } eval_state_e;

   // Clamp a one-bit-wider signed sum back into the 16-bit signed range.
   // Overflow shows up as the two top bits disagreeing; the top bit gives the true sign.
   function automatic logic signed [DATA_WIDTH_16-1:0] sat_clamp_16(
      input logic signed [DATA_WIDTH_16:0] wide
   );
      logic signed [DATA_WIDTH_16-1:0] result;
      if (wide[DATA_WIDTH_16] != wide[DATA_WIDTH_16-1]) begin
         result = wide[DATA_WIDTH_16] ? SAT_MIN_16 : SAT_MAX_16;
      end else begin
         result = wide[DATA_WIDTH_16-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/stage_threshold_evaluator_sat_accumulator.sv
// Saturating signed accumulator: sign-extends a 12-bit operand, adds it to the
// running 16-bit sum and clamps every addition so the sum never wraps.
module stage_threshold_evaluator_sat_accumulator
   import stage_threshold_evaluator_pkg::*;
(
   input  logic                            clk_fpga,
   input  logic                            reset_fpga,
   input  logic                            i_clear,
   input  logic                            i_enable,
   input  logic signed [DATA_WIDTH_12-1:0] i_operand,
   output logic signed [DATA_WIDTH_16-1:0] o_sum
);

   localparam int unsigned ExtBits = DATA_WIDTH_16 + 1 - DATA_WIDTH_12;

   logic signed [DATA_WIDTH_16-1:0] r_sum;
   logic signed [DATA_WIDTH_16:0]   w_operand_ext;
   logic signed [DATA_WIDTH_16:0]   w_sum_wide;
   logic signed [DATA_WIDTH_16-1:0] w_sum_next;

   // Widen both terms by one bit so the raw add cannot overflow, then clamp.
   always_comb begin
      w_operand_ext = {{ExtBits{i_operand[DATA_WIDTH_12-1]}}, i_operand};
      w_sum_wide    = {r_sum[DATA_WIDTH_16-1], r_sum} + w_operand_ext;
      w_sum_next    = sat_clamp_16(w_sum_wide);
   end

   // Sum register: clear wins over accumulate.
   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         r_sum <= '0;
      end else if (i_clear) begin
         r_sum <= '0;
      end else if (i_enable) begin
         r_sum <= w_sum_next;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/stage_threshold_evaluator.sv
// Cascade stage threshold evaluator: accumulates the haar values of each stage,
// compares the stage sum with the stage threshold and either advances to the
// next stage (pulsing the upstream trigger) or ends the window with a decision.
module stage_threshold_evaluator
   import stage_threshold_evaluator_pkg::*;
(
   input  logic                            clk_fpga,
   input  logic                            reset_fpga,
   input  logic                            i_start_window,
   input  logic                            i_haar_valid,
   input  logic signed [DATA_WIDTH_12-1:0] i_haar_value,
   input  logic                            i_is_end_of_stage,
   input  logic signed [DATA_WIDTH_16-1:0] i_stage_threshold,
   input  logic        [DATA_WIDTH_8-1:0]  i_num_stages,
   output logic                            o_trigger_next_stage,
   output logic        [DATA_WIDTH_8-1:0]  o_stage_index,
   output logic signed [DATA_WIDTH_16-1:0] o_stage_sum,
   output logic                            o_busy,
   output logic                            o_result_valid,
   output logic                            o_is_candidate,
   output logic                            o_protocol_err
);

   eval_state_e                     r_state;
   logic        [DATA_WIDTH_8-1:0]  r_stage_index;
   logic        [DATA_WIDTH_8-1:0]  r_num_stages;
   logic                            r_trigger;
   logic                            r_result_valid;
   logic                            r_candidate;
   logic                            r_protocol_err;

   logic signed [DATA_WIDTH_16-1:0] w_stage_sum;
   logic                            w_pass;
   logic                            w_last_stage;
   logic                            w_start_accept;
   logic                            w_advance;
   logic                            w_acc_clear;
   logic                            w_acc_enable;

   // Stage decision terms and accumulator controls.
   always_comb begin
      w_pass         = (w_stage_sum >= i_stage_threshold);
      w_last_stage   = (r_stage_index == (r_num_stages - 8'd1));
      w_start_accept = (r_state == StIdle) && i_start_window;
      w_advance      = (r_state == StCompare) && w_pass && !w_last_stage;
      w_acc_clear    = w_start_accept || w_advance;
      // A zero-stage window passes through ACCUM once without accumulating.
      w_acc_enable   = (r_state == StAccum) && i_haar_valid && (r_num_stages != '0);
   end

   stage_threshold_evaluator_sat_accumulator u_sat_accumulator (
      .clk_fpga   (clk_fpga),
      .reset_fpga (reset_fpga),
      .i_clear    (w_acc_clear),
      .i_enable   (w_acc_enable),
      .i_operand  (i_haar_value),
      .o_sum      (w_stage_sum)
   );

   // Window FSM with stage counter and registered outputs.
   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         r_state        <= StIdle;
         r_stage_index  <= '0;
         r_num_stages   <= '0;
         r_trigger      <= 1'b0;
         r_result_valid <= 1'b0;
         r_candidate    <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_trigger      <= 1'b0;
         r_result_valid <= 1'b0;

         // Haar data is only meaningful while accumulating; anything else is a
         // sequencing fault upstream and is latched until reset.
         if (i_haar_valid && (r_state != StAccum)) begin
            r_protocol_err <= 1'b1;
         end

         unique case (r_state)
            StIdle: begin
               if (i_start_window) begin
                  r_stage_index <= '0;
                  r_num_stages  <= i_num_stages;
                  r_candidate   <= 1'b0;
                  // An empty cascade never asks upstream for data.
                  r_trigger     <= (i_num_stages != '0);
                  r_state       <= StAccum;
               end
            end

            StAccum: begin
               if (r_num_stages == '0) begin
                  r_candidate    <= 1'b0;
                  r_result_valid <= 1'b1;
                  r_state        <= StResult;
               end else if (i_haar_valid && i_is_end_of_stage) begin
                  r_state <= StCompare;
               end
            end

            StCompare: begin
               if (!w_pass) begin
                  r_candidate    <= 1'b0;
                  r_result_valid <= 1'b1;
                  r_state        <= StResult;
               end else if (w_last_stage) begin
                  r_candidate    <= 1'b1;
                  r_result_valid <= 1'b1;
                  r_state        <= StResult;
               end else begin
                  r_stage_index <= r_stage_index + 8'd1;
                  r_trigger     <= 1'b1;
                  r_state       <= StAccum;
               end
            end

            StResult: begin
               r_state <= StIdle;
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_trigger_next_stage = r_trigger;
   assign o_stage_index        = r_stage_index;
   assign o_stage_sum          = w_stage_sum;
   assign o_busy               = (r_state != StIdle);
   assign o_result_valid       = r_result_valid;
   assign o_is_candidate       = r_candidate;
   assign o_protocol_err       = r_protocol_err;

endmodule

// File: tb/tb_stage_threshold_evaluator.sv
// Bench for stage_threshold_evaluator: directed cascade scenarios plus random
// windows, all checked against a stage-by-stage arithmetic reference model.
module tb_stage_threshold_evaluator;

   localparam int MaxStages = 8;
   localparam int MaxLen    = 32;

   logic        clk_fpga;
   logic        reset_fpga;
   logic        i_start_window;
   logic        i_haar_valid;
   logic [11:0] i_haar_value;
   logic        i_is_end_of_stage;
   logic [15:0] i_stage_threshold;
   logic [7:0]  i_num_stages;
   logic        o_trigger_next_stage;
   logic [7:0]  o_stage_index;
   logic [15:0] o_stage_sum;
   logic        o_busy;
   logic        o_result_valid;
   logic        o_is_candidate;
   logic        o_protocol_err;

   int n_checks;
   int n_errors;
   int trig_count;
   int exp_perr;

   int thr  [MaxStages];
   int slen [MaxStages];
   int hv   [MaxStages][MaxLen];

   stage_threshold_evaluator dut (
      .clk_fpga             (clk_fpga),
      .reset_fpga           (reset_fpga),
      .i_start_window       (i_start_window),
      .i_haar_valid         (i_haar_valid),
      .i_haar_value         (i_haar_value),
      .i_is_end_of_stage    (i_is_end_of_stage),
      .i_stage_threshold    (i_stage_threshold),
      .i_num_stages         (i_num_stages),
      .o_trigger_next_stage (o_trigger_next_stage),
      .o_stage_index        (o_stage_index),
      .o_stage_sum          (o_stage_sum),
      .o_busy               (o_busy),
      .o_result_valid       (o_result_valid),
      .o_is_candidate       (o_is_candidate),
      .o_protocol_err       (o_protocol_err)
   );

   initial clk_fpga = 1'b0;
   always #5 clk_fpga = ~clk_fpga;

   // Count upstream trigger pulses mid-cycle.
   always @(negedge clk_fpga) begin
      if (o_trigger_next_stage === 1'b1) trig_count = trig_count + 1;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   task automatic step();
      @(posedge clk_fpga);
      #1;
   endtask

   task automatic fill_stage(input int s, input int th, input int len, input int v);
      thr[s]  = th;
      slen[s] = len;
      for (int i = 0; i < len; i++) hv[s][i] = v;
   endtask

   task automatic idle_inputs();
      i_start_window    = 1'b0;
      i_haar_valid      = 1'b0;
      i_haar_value      = '0;
      i_is_end_of_stage = 1'b0;
   endtask

   // Run one window of n stages from the global tables and check it against the model.
   task automatic run_window(input int n, input bit inj_start, input bit inj_cmp_hv);
      int ssum [MaxStages];
      int exp_end;
      int exp_cand;
      int cnt0;
      int gaps;

      // Reference model: each stage sums from zero with per-add clamping, then
      // the window ends at the first failing stage or after the last stage.
      exp_end  = -1;
      exp_cand = 0;
      for (int s = 0; s < n; s++) begin
         ssum[s] = 0;
         for (int i = 0; i < slen[s]; i++) ssum[s] = sat16(ssum[s] + hv[s][i]);
         if (ssum[s] < thr[s]) begin
            exp_end = s;
            exp_cand = 0;
            break;
         end
         if (s == n - 1) begin
            exp_end = s;
            exp_cand = 1;
         end
      end

      cnt0 = trig_count;
      i_start_window = 1'b1;
      i_num_stages   = 8'(n);
      step();
      i_start_window = 1'b0;
      i_num_stages   = 8'($urandom_range(0, 255));
      check_eq("busy_after_start", o_busy, 1);

      if (n == 0) begin
         check_eq("zero_no_trigger", o_trigger_next_stage, 0);
         step();
         check_eq("zero_result_valid", o_result_valid, 1);
         check_eq("zero_candidate", o_is_candidate, 0);
         check_eq("zero_sum", $signed(o_stage_sum), 0);
      end else begin
         for (int s = 0; s <= exp_end; s++) begin
            check_eq("stage_trigger", o_trigger_next_stage, 1);
            check_eq("stage_index", o_stage_index, s);
            i_stage_threshold = 16'(thr[s]);
            for (int i = 0; i < slen[s]; i++) begin
               gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
               for (int g = 0; g < gaps; g++) begin
                  i_haar_valid      = 1'b0;
                  i_is_end_of_stage = 1'($urandom_range(0, 1));
                  i_haar_value      = 12'($urandom_range(0, 4095));
                  step();
               end
               i_haar_valid      = 1'b1;
               i_haar_value      = 12'(hv[s][i]);
               i_is_end_of_stage = (i == slen[s] - 1);
               if (inj_start && s == 0 && i == 0) begin
                  i_start_window = 1'b1;
                  i_num_stages   = 8'd0;
               end
               step();
               i_start_window = 1'b0;
            end
            idle_inputs();
            check_eq("compare_sum", $signed(o_stage_sum), ssum[s]);
            check_eq("compare_busy", o_busy, 1);
            if (inj_cmp_hv) begin
               i_haar_valid = 1'b1;
               i_haar_value = 12'd100;
               exp_perr     = 1;
            end
            step();
            i_haar_valid = 1'b0;
            if (s == exp_end) begin
               check_eq("result_valid", o_result_valid, 1);
               check_eq("result_candidate", o_is_candidate, exp_cand);
               check_eq("result_index", o_stage_index, s);
               check_eq("result_no_trigger", o_trigger_next_stage, 0);
               check_eq("result_sum", $signed(o_stage_sum), ssum[s]);
            end else begin
               check_eq("advance_no_result", o_result_valid, 0);
               check_eq("advance_sum_clear", $signed(o_stage_sum), 0);
            end
         end
      end
      step();
      check_eq("end_result_pulse", o_result_valid, 0);
      check_eq("end_idle", o_busy, 0);
      check_eq("end_candidate_held", o_is_candidate, exp_cand);
      check_eq("end_protocol_err", o_protocol_err, exp_perr);
      check_eq("trigger_count", trig_count - cnt0, exp_end + 1);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_trigger"}, o_trigger_next_stage, 0);
      check_eq({tag, "_index"}, o_stage_index, 0);
      check_eq({tag, "_sum"}, $signed(o_stage_sum), 0);
      check_eq({tag, "_busy"}, o_busy, 0);
      check_eq({tag, "_rvalid"}, o_result_valid, 0);
      check_eq({tag, "_cand"}, o_is_candidate, 0);
      check_eq({tag, "_perr"}, o_protocol_err, 0);
   endtask

   initial begin
      int n;
      n_checks   = 0;
      n_errors   = 0;
      trig_count = 0;
      exp_perr   = 0;
      reset_fpga = 1'b0;
      idle_inputs();
      i_stage_threshold = '0;
      i_num_stages      = '0;
      #12;
      check_all_zero("reset");
      @(negedge clk_fpga);
      reset_fpga = 1'b1;
      step();

      // Two stages, both passing.
      fill_stage(0, 10, 3, 4);
      fill_stage(1, 5, 2, 3);
      run_window(2, 1'b0, 1'b0);

      // First stage fails.
      fill_stage(0, 20, 2, 5);
      fill_stage(1, 0, 1, 1);
      fill_stage(2, 0, 1, 1);
      run_window(3, 1'b0, 1'b0);

      // Positive and negative saturation, then recovery from a clamped sum.
      fill_stage(0, 32767, 20, 2047);
      fill_stage(1, -32768, 20, -2048);
      fill_stage(2, 30719, 18, 2047);
      hv[2][17] = -2048;
      run_window(3, 1'b0, 1'b0);

      // Empty cascade.
      run_window(0, 1'b0, 1'b0);

      // Random windows.
      for (int w = 0; w < 40; w++) begin
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
         for (int s = 0; s < n; s++) begin
            int acc;
            slen[s] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 24))
                                                   : int'($urandom_range(1, 6));
            acc = 0;
            for (int i = 0; i < slen[s]; i++) begin
               hv[s][i] = int'($urandom_range(0, 4095)) - 2048;
               acc = sat16(acc + hv[s][i]);
            end
            thr[s] = sat16(acc + int'($urandom_range(0, 8)) - 6);
         end
         run_window(n, 1'b0, 1'b0);
      end

      // Stray start during ACCUM and haar data during COMPARE.
      fill_stage(0, 20, 2, 5);
      fill_stage(1, 0, 1, 1);
      fill_stage(2, 0, 1, 1);
      run_window(3, 1'b1, 1'b1);

      // Asynchronous reset mid-ACCUM with stage 1 holding a partial sum of 37.
      fill_stage(0, 0, 1, 5);
      i_start_window = 1'b1;
      i_num_stages   = 8'd3;
      step();
      i_start_window    = 1'b0;
      i_stage_threshold = 16'd0;
      i_haar_valid      = 1'b1;
      i_haar_value      = 12'd5;
      i_is_end_of_stage = 1'b1;
      step();
      idle_inputs();
      step();
      i_haar_valid = 1'b1;
      i_haar_value = 12'd30;
      step();
      i_haar_value = 12'd7;
      step();
      idle_inputs();
      check_eq("pre_reset_sum", $signed(o_stage_sum), 37);
      check_eq("pre_reset_index", o_stage_index, 1);
      check_eq("pre_reset_perr", o_protocol_err, 1);
      #3;
      reset_fpga = 1'b0;
      #1;
      check_all_zero("async_reset");
      step();
      check_eq("reset_no_result", o_result_valid, 0);
      reset_fpga = 1'b1;
      exp_perr   = 0;
      step();

      // Fresh window after reset starts from stage 0 with a zero sum.
      fill_stage(0, 10, 3, 4);
      fill_stage(1, 5, 2, 3);
      run_window(2, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
